// File: rtl/mfc_bus_sequencer.sv
// Purpose : one load/store request at a time to RAM over the four-phase MFA/MFC handshake; dword is split into two word beats.
// Latency : accept edge T, ramMFA high from T, done one cycle after MFC drops (aligned word with MFC one cycle after MFA: done at T+4).
// Backpressure: req_ready is high only in S_IDLE; requests while busy, including the S_DONE cycle, are ignored and not queued.
//
// Ports:
//   Clk, reset (synchronous, active-high)
//   req/req_rw/req_size/req_addr/req_wdata : request side, accepted when req && req_ready
//   req_ready, done, err, rdata            : status and read data back to the control unit
//   ramMFA/ramRW/ramAddress/ramDataSize/ramDataOut/ramDataIn/ramMFC : RAM handshake side
//
// Optional feature: define BUS_TIMEOUT_EN to abort an S_WAIT that lasts TIMEOUT cycles
// without ramMFC (err=1, any remaining dword beat skipped). Without it, S_WAIT waits forever.

module mfc_bus_sequencer #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                Clk,
    input  logic                reset,
    input  logic                req,
    input  logic                req_rw,
    input  logic [1:0]          req_size,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic                req_ready,
    output logic                done,
    output logic                err,
    output logic [2*DATA_W-1:0] rdata,
    output logic                ramMFA,
    output logic                ramRW,
    output logic [ADDR_W-1:0]   ramAddress,
    output logic [1:0]          ramDataSize,
    output logic [DATA_W-1:0]   ramDataOut,
    input  logic [DATA_W-1:0]   ramDataIn,
    input  logic                ramMFC
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_REL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    state_t              state;
    state_t              stateNext;
    logic                accept;
    logic                capture;
    logic                nextBeat;
    logic                timeoutHit;
    logic                misaligned;
    logic                beat;
    logic                errQ;
    logic [1:0]          sizeQ;
    logic [DATA_W-1:0]   wdataHiQ;

    // Alignment is judged on the raw request so a bad access never enters S_WAIT.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            SZ_HALF:  misaligned = req_addr[0];
            SZ_WORD:  misaligned = |req_addr[1:0];
            SZ_DWORD: misaligned = |req_addr[2:0];
            default:  misaligned = 1'b0;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    localparam int TimerW = $clog2(TIMEOUT + 1);
    logic [TimerW-1:0] timer;
    logic              timerExpired;

    assign timerExpired = (timer == TimerW'(TIMEOUT - 1));

    // Counts completed S_WAIT cycles; restarts on every entry to S_WAIT.
    always_ff @(posedge Clk) begin
        if (reset) begin
            timer <= '0;
        end else if (accept || nextBeat) begin
            timer <= '0;
        end else if (state == S_WAIT) begin
            timer <= timer + 1'b1;
        end
    end
`else
    logic timerExpired;
    assign timerExpired = 1'b0;
`endif

    always_comb begin
        stateNext  = state;
        accept     = 1'b0;
        capture    = 1'b0;
        nextBeat   = 1'b0;
        timeoutHit = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    stateNext = misaligned ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                // MFC already high on entry counts as completion.
                if (ramMFC) begin
                    capture   = 1'b1;
                    stateNext = S_REL;
                end else if (timerExpired) begin
                    timeoutHit = 1'b1;
                    stateNext  = S_DONE;
                end
            end
            S_REL: begin
                // Hold off until MFC falls so MFA is never raised against a high MFC.
                if (!ramMFC) begin
                    if ((sizeQ == SZ_DWORD) && !beat) begin
                        nextBeat  = 1'b1;
                        stateNext = S_WAIT;
                    end else begin
                        stateNext = S_DONE;
                    end
                end
            end
            S_DONE:  stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state       <= S_IDLE;
            beat        <= 1'b0;
            errQ        <= 1'b0;
            sizeQ       <= SZ_BYTE;
            wdataHiQ    <= '0;
            rdata       <= '0;
            ramRW       <= 1'b1;
            ramAddress  <= '0;
            ramDataSize <= SZ_BYTE;
            ramDataOut  <= '0;
        end else begin
            state <= stateNext;

            if (accept) begin
                beat        <= 1'b0;
                errQ        <= misaligned;
                sizeQ       <= req_size;
                wdataHiQ    <= req_wdata[2*DATA_W-1:DATA_W];
                rdata       <= '0;
                ramRW       <= req_rw;
                ramAddress  <= req_addr;
                ramDataSize <= (req_size == SZ_DWORD) ? SZ_WORD : req_size;
                ramDataOut  <= req_wdata[DATA_W-1:0];
            end

            // rdata was cleared at accept, so narrow reads land zero-extended.
            if (capture && ramRW) begin
                case (sizeQ)
                    SZ_BYTE:  rdata[DATA_W-1:0] <= DATA_W'(ramDataIn[7:0]);
                    SZ_HALF:  rdata[DATA_W-1:0] <= DATA_W'(ramDataIn[15:0]);
                    SZ_WORD:  rdata[DATA_W-1:0] <= ramDataIn;
                    default: begin
                        if (beat) begin
                            rdata[2*DATA_W-1:DATA_W] <= ramDataIn;
                        end else begin
                            rdata[DATA_W-1:0] <= ramDataIn;
                        end
                    end
                endcase
            end

            // Second dword beat: next word address, wrapping within the address space.
            if (nextBeat) begin
                beat       <= 1'b1;
                ramAddress <= ramAddress + ADDR_W'(DATA_W / 8);
                ramDataOut <= wdataHiQ;
            end

            if (timeoutHit) begin
                errQ <= 1'b1;
            end
        end
    end

    assign req_ready = (state == S_IDLE);
    assign done      = (state == S_DONE);
    assign err       = (state == S_DONE) && errQ;
    assign ramMFA    = (state == S_WAIT);

endmodule
